// File: rtl/hssaer_paer_rx.sv
// -----------------------------------------------------------------------------
// hssaer_paer_rx
//
// Receive end of the HSSAER serial link. The asynchronous serial line is
// synchronized and oversampled on the local clock. Each frame is validated
// (start, flag, data, parity, stop). Address-events are delivered on a
// src_rdy/dst_rdy handshake. Keep-alive frames are consumed internally and
// only refresh the link-alive indication.
//
// Frame, in bit order: start(0), flag, d[0]..d[dsize-1], parity (odd over
// flag+data), stop(1).
//
// Ports:
//   clk        in   receiver clock, rising edge
//   nrst       in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   ae         out  received event (zero-extended payload), valid with src_rdy
//   src_rdy    out  ae holds a valid event
//   dst_rdy    in   consumer accepts ae when src_rdy and dst_rdy are both high
//   run        out  a good frame was seen within the last TIMEOUT cycles
//   parity_err out  one-cycle pulse: frame dropped on parity mismatch
//   frame_err  out  one-cycle pulse: frame dropped on stop bit of 0
//   overflow   out  one-cycle pulse: good event dropped, output register full
// -----------------------------------------------------------------------------
module hssaer_paer_rx #(
  parameter int dsize     = 8,
  parameter int int_dsize = 24,
  parameter int OVS       = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx,
  output logic [int_dsize-1:0] ae,
  output logic                 src_rdy,
  input  logic                 dst_rdy,
  output logic                 run,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int TW = $clog2(OVS + 1);
  localparam int SW = dsize + 2;
  localparam int CW = $clog2(dsize + 2);
  localparam int RW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0] HALF_LOAD = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(OVS - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(dsize + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [SW-1:0] sreg, sreg_next;
  logic [RW-1:0] run_timer;

  logic rx_m, rx_s;
  logic expire;
  logic eval_event, eval_ka, eval_perr, eval_ferr;
  logic accept;

  // Two-flop synchronizer; flops reset to the idle line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      cnt   <= cnt_next;
      sreg  <= sreg_next;
    end
  end

  assign expire = (timer == '0);

  // Samples shift in at the MSB, so once all flag/data/parity samples are in,
  // sreg[0] is the flag, sreg[dsize:1] the data and sreg[dsize+1] the parity.
  always_comb begin
    state_next = state;
    timer_next = timer;
    cnt_next   = cnt;
    sreg_next  = sreg;
    eval_event = 1'b0;
    eval_ka    = 1'b0;
    eval_perr  = 1'b0;
    eval_ferr  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          timer_next = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            state_next = SHIFT;
            cnt_next   = '0;
            timer_next = FULL_LOAD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      SHIFT: begin
        if (expire) begin
          sreg_next  = {rx_s, sreg[SW-1:1]};
          timer_next = FULL_LOAD;
          if (cnt == LAST_CNT) begin
            state_next = STOP;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      STOP: begin
        if (expire) begin
          if (!rx_s) begin
            eval_ferr  = 1'b1;
            state_next = BREAK;
          end else if (!(^sreg)) begin
            eval_perr  = 1'b1;
            state_next = IDLE;
          end else if (sreg[0]) begin
            eval_ka    = 1'b1;
            state_next = IDLE;
          end else begin
            eval_event = 1'b1;
            state_next = IDLE;
          end
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept = src_rdy & dst_rdy;

  // Single-entry output register. A new event may replace the held one only
  // in the cycle the held one is being accepted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ae         <= '0;
      src_rdy    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= eval_perr;
      frame_err  <= eval_ferr;
      overflow   <= 1'b0;
      if (eval_event) begin
        if (!src_rdy || accept) begin
          ae      <= int_dsize'(sreg[dsize:1]);
          src_rdy <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (accept) begin
        src_rdy <= 1'b0;
      end
    end
  end

  // Link-alive timer, reloaded by any good frame, saturating at zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run_timer <= '0;
    end else if (eval_event || eval_ka) begin
      run_timer <= RW'(TIMEOUT);
    end else if (run_timer != '0) begin
      run_timer <= run_timer - RW'(1);
    end
  end

  assign run = (run_timer != '0);

endmodule

// File: tb/tb_hssaer_paer_rx.sv
// -----------------------------------------------------------------------------
// tb_hssaer_paer_rx
//
// Self-checking bench for hssaer_paer_rx (dsize=8, int_dsize=24, OVS=4,
// TIMEOUT=64). Frames are bit-banged on rx; a table of frames is checked at
// the cycle after the stop-bit sample, and a scoreboard queue tracks every
// event that should be handed to the consumer.
// -----------------------------------------------------------------------------
module tb_hssaer_paer_rx;

  localparam int DS  = 8;
  localparam int IDS = 24;
  localparam int OV  = 4;
  localparam int TO  = 64;

  logic           clk = 1'b0;
  logic           nrst;
  logic           rx;
  logic [IDS-1:0] ae;
  logic           src_rdy;
  logic           dst_rdy;
  logic           run;
  logic           parity_err;
  logic           frame_err;
  logic           overflow;

  int tests = 0;
  int fails = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [IDS-1:0] exp_q[$];

  hssaer_paer_rx #(
    .dsize(DS),
    .int_dsize(IDS),
    .OVS(OV),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .rx(rx),
    .ae(ae),
    .src_rdy(src_rdy),
    .dst_rdy(dst_rdy),
    .run(run),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       flag;
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_src;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the first nbits bits of a frame, OVS cycles each, starting #1 after
  // a rising edge; returns #1 after the edge that ends the last bit (cycle E
  // for a full frame). Good events with push set go into the scoreboard.
  task automatic applyStimulus(input logic flag, input logic [7:0] data, input logic bad_par,
                               input logic bad_stop, input logic push, input int nbits);
    logic [11:0] bits;
    logic        par;
    par  = ~(^{flag, data}) ^ bad_par;
    bits = {~bad_stop, par, data, flag, 1'b0};
    if (push && !flag && !bad_par && !bad_stop) exp_q.push_back(IDS'(data));
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (OV) @(posedge clk);
      #1;
    end
  endtask

  // Pulse counters and consumer-side scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [IDS-1:0] e;
    if (nrst) begin
      if (parity_err) perr_cnt++;
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (src_rdy && dst_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL scoreboard: got event 0x%0h, expected none", ae);
        end else begin
          e = exp_q.pop_front();
          checkOutput("scoreboard ae", 32'(ae), 32'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ferr0, perr0, ovf0;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h3D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    nrst    = 1'b0;
    rx      = 1'b1;
    dst_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ae", 32'(ae), 32'h0);
    checkOutput("reset src_rdy", 32'(src_rdy), 32'h0);
    checkOutput("reset run", 32'(run), 32'h0);
    checkOutput("reset pulses", 32'({parity_err, frame_err, overflow}), 32'h0);
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      ferr0 = ferr_cnt;
      applyStimulus(vecs[i].flag, vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 1'b1, 12);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d src_rdy", i), 32'(src_rdy), 32'(vecs[i].exp_src));
      checkOutput($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
      checkOutput($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      checkOutput($sformatf("vec%0d overflow", i), 32'(overflow), 32'h0);
      if (vecs[i].exp_src) checkOutput($sformatf("vec%0d ae", i), 32'(ae), 32'(vecs[i].data));
      if (!vecs[i].exp_perr && !vecs[i].exp_ferr) checkOutput($sformatf("vec%0d run", i), 32'(run), 32'h1);
      if (vecs[i].bad_stop) begin
        repeat (20 * OV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * OV) @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d frame_err count", i), 32'(ferr_cnt - ferr0), 32'h1);
        checkOutput($sformatf("vec%0d no spurious event", i), 32'(src_rdy), 32'h0);
      end
    end

    // Keep-alive: run rises at E+1 and falls exactly TIMEOUT cycles later.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 12);
    @(posedge clk);
    #1;
    checkOutput("keepalive run rise", 32'(run), 32'h1);
    checkOutput("keepalive src_rdy", 32'(src_rdy), 32'h0);
    repeat (TO - 1) @(posedge clk);
    #1;
    checkOutput("keepalive run last cycle", 32'(run), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("keepalive run fall", 32'(run), 32'h0);

    // Back-to-back events with a stalled consumer.
    ovf0    = ovf_cnt;
    dst_rdy = 1'b0;
    applyStimulus(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 12);
    applyStimulus(1'b0, 8'h02, 1'b0, 1'b0, 1'b1 ^ 1'b1, 12);
    @(posedge clk);
    #1;
    checkOutput("overflow pulse", 32'(overflow), 32'h1);
    checkOutput("overflow src_rdy held", 32'(src_rdy), 32'h1);
    checkOutput("overflow ae held", 32'(ae), 32'h01);
    dst_rdy = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("overflow accepted src_rdy", 32'(src_rdy), 32'h0);
    checkOutput("overflow count", 32'(ovf_cnt - ovf0), 32'h1);

    // One-cycle glitch in IDLE.
    perr0 = perr_cnt;
    ferr0 = ferr_cnt;
    ovf0  = ovf_cnt;
    rx    = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("glitch src_rdy", 32'(src_rdy), 32'h0);
    checkOutput("glitch pulses", 32'((perr_cnt - perr0) + (ferr_cnt - ferr0) + (ovf_cnt - ovf0)), 32'h0);

    // Reset mid-SHIFT while an event is held.
    dst_rdy = 1'b0;
    applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 12);
    @(posedge clk);
    #1;
    checkOutput("pre-reset held event", 32'(src_rdy), 32'h1);
    applyStimulus(1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, 5);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("async reset ae", 32'(ae), 32'h0);
    checkOutput("async reset src_rdy", 32'(src_rdy), 32'h0);
    checkOutput("async reset run", 32'(run), 32'h0);
    checkOutput("async reset pulses", 32'({parity_err, frame_err, overflow}), 32'h0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nrst    = 1'b1;
    dst_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1, 12);
    @(posedge clk);
    #1;
    checkOutput("post-reset src_rdy", 32'(src_rdy), 32'h1);
    checkOutput("post-reset ae", 32'(ae), 32'h7E);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hssaer_paer_rx.md
# hssaer_paer_rx

Receive end of the HSSAER serial link. It oversamples the incoming serial line on a single local clock and validates each frame (start, flag, data, parity, stop). It recovers address-events and delivers them on a parallel src_rdy/dst_rdy handshake toward the HPU core. Keep-alive frames are consumed internally to maintain a link-alive indication.

## Interface
- dsize, 8, event payload bits carried per frame
- int_dsize, 24, width of the parallel ae output; payload is zero-extended (int_dsize >= dsize)
- OVS, 4, oversampling factor in clk cycles per serial bit; even, >= 4
- TIMEOUT, 1024, clk cycles without a good frame before run deasserts; >= 2
- clk  input  1  receiver clock; all logic on rising edge
- nrst  input  1  asynchronous, active-low reset
- rx  input  1  serial line, asynchronous to clk, idle high
- ae  output  int_dsize  received event, valid while src_rdy=1
- src_rdy  output  1  ae holds a valid event
- dst_rdy  input  1  consumer accepts ae when src_rdy=1 and dst_rdy=1
- run  output  1  link alive: a good frame was seen within TIMEOUT cycles
- parity_err  output  1  one-cycle pulse, frame dropped on a parity mismatch
- frame_err  output  1  one-cycle pulse, frame dropped on a stop bit of 0
- overflow  output  1  one-cycle pulse, good data frame dropped because the output register was full

## Operation
- Frame, in bit order: start(0), flag, d[0]..d[dsize-1] (LSB first), parity, stop(1). Total dsize+4 bits.
- flag=1 marks a keep-alive frame; its data bits are ignored. flag=0 marks an event.
- Parity is odd over flag and data: the XOR of flag, data and parity must be 1.
- rx passes through a 2-flop synchronizer (rx_s). Everything below uses rx_s.
- State IDLE: when rx_s=0, load the bit timer with OVS/2-1 and go to START.
- State START: at timer expiry (mid start bit), if rx_s=0, go to SHIFT with bit count 0 and timer OVS-1. Otherwise treat it as a glitch: return to IDLE with no error pulse.
- State SHIFT: at each timer expiry, sample rx_s into the shift register and reload the timer to OVS-1. After dsize+2 samples (flag, data, parity), go to STOP.
- State STOP: at timer expiry, sample the stop bit and evaluate the frame, in this priority order:
  - stop=0: pulse frame_err, go to BREAK.
  - parity bad: pulse parity_err, go to IDLE.
  - flag=1: good keep-alive, go to IDLE.
  - flag=0: good event, go to IDLE.
- State BREAK: wait until rx_s=1, then go to IDLE.
- Any good frame (event or keep-alive) reloads the run timer.
- Output register, one entry:
  - A good event loads {zeros, data} and sets src_rdy, provided the register is empty or is being accepted in the same cycle (src_rdy and dst_rdy both high).
  - Otherwise the event is dropped and overflow pulses. The held ae is unchanged.
- src_rdy clears on acceptance unless it is reloaded in the same cycle. ae is stable while src_rdy=1 and not accepted.
- run timer: counts down once per cycle, saturating at 0. run=1 while the timer is nonzero. A good frame reloads it to TIMEOUT.

## Timing
- Reset (nrst=0, takes effect asynchronously):
  - State IDLE, synchronizer flops at 1.
  - ae=0, src_rdy=0, run=0.
  - parity_err=0, frame_err=0, overflow=0.
- Reset mid-frame discards the partial frame and the held event. After release, the receiver waits in IDLE for the next falling edge.
- Synchronizer latency is 2 cycles.
- Start detect to the mid start-bit sample is OVS/2 cycles. Consecutive samples are exactly OVS cycles apart.
- The stop-bit sample cycle is E. In cycle E+1:
  - src_rdy=1 and ae are valid, or exactly one of parity_err / frame_err / overflow is high for one cycle.
  - run=1 if the frame was good.
- Back-to-back frames with no idle bits are received without loss: IDLE can detect the next start edge from cycle E+1.
- Throughput: one event per (dsize+4)*OVS cycles. The consumer must accept within one frame time or overflow occurs.
- run drops exactly TIMEOUT cycles after the last good-frame evaluation cycle.

## Test plan
(All scenarios use dsize=8, int_dsize=24, OVS=4, TIMEOUT=64.)
- Event frame, data 0xA5, flag 0, parity 1, dst_rdy=1 -> src_rdy pulses for 1 cycle at E+1 with ae=0x0000A5. run=1. No error pulses.
- Keep-alive frame (flag 1, data 0x00, parity 0) -> src_rdy stays 0. run rises at E+1 and falls 64 cycles later.
- Frame 0x3C with the parity bit inverted -> parity_err pulses once, src_rdy=0. A following good frame 0x3D -> ae=0x00003D.
- Stop bit forced 0, line held low for 20 bit times, then idle -> one frame_err pulse, no spurious frames. The next frame 0x11 is received correctly.
- dst_rdy=0 with two back-to-back events 0x01 then 0x02 -> ae stays 0x000001 with src_rdy=1, overflow pulses at the second frame's E+1. Raising dst_rdy then accepts 0x01 and src_rdy clears.
- A 1-cycle low glitch on rx in IDLE -> no state change beyond START, no pulses. nrst asserted mid-SHIFT -> all outputs 0 immediately, and the next clean frame 0x7E is received.
